// File: rtl/gpio_bank_if.sv
// Request/response bus between the core interconnect and a GPIO bank.
// One accepted request yields exactly one response strobe on the next cycle.
interface gpio_bank_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: registered pad-control pins, synchronized pad inputs
// and a level interrupt raised on configured rising/falling edges.
module gpio_bank #(
  parameter int NUM_PADS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  gpio_bank_if.slave          bus,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] pad_cs,
  output logic [NUM_PADS-1:0] pad_sl,
  output logic [NUM_PADS-1:0] pad_ie,
  output logic [NUM_PADS-1:0] pad_pu,
  output logic [NUM_PADS-1:0] pad_pd,
  output logic                irq
);

  typedef enum logic [3:0] {
    ADDR_OUT        = 4'd0,
    ADDR_OE         = 4'd1,
    ADDR_IN         = 4'd2,
    ADDR_PU         = 4'd3,
    ADDR_PD         = 4'd4,
    ADDR_CS         = 4'd5,
    ADDR_SL         = 4'd6,
    ADDR_IE         = 4'd7,
    ADDR_RISE_EN    = 4'd8,
    ADDR_FALL_EN    = 4'd9,
    ADDR_IRQ_STATUS = 4'd10,
    ADDR_OUT_SET    = 4'd11,
    ADDR_OUT_CLR    = 4'd12
  } reg_addr_e;

  typedef logic [NUM_PADS-1:0] pads_t;

  pads_t       out_r, oe_r, pu_r, pd_r, cs_r, sl_r, ie_r;
  pads_t       rise_en_r, fall_en_r, irq_status_r;
  pads_t       s1, s2, s3;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        irq_r;

  logic        accept;
  logic        wr_en;
  pads_t       wdata_p;
  pads_t       edge_set;
  pads_t       w1c_clr;
  logic [31:0] rd_data;

  function automatic logic [31:0] widen(input pads_t v);
    logic [31:0] w;
    w = '0;
    w[NUM_PADS-1:0] = v;
    return w;
  endfunction

  assign bus.req_ready  = ~resp_valid_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;

  assign accept  = bus.req_valid & bus.req_ready;
  assign wr_en   = accept & bus.req_write;
  assign wdata_p = bus.req_wdata[NUM_PADS-1:0];

  assign edge_set = (s2 & ~s3 & rise_en_r) | (~s2 & s3 & fall_en_r);
  assign w1c_clr  = (wr_en && bus.req_addr == ADDR_IRQ_STATUS) ? wdata_p : '0;

  always_comb begin
    rd_data = '0;
    case (bus.req_addr)
      ADDR_OUT:        rd_data = widen(out_r);
      ADDR_OE:         rd_data = widen(oe_r);
      ADDR_IN:         rd_data = widen(s2);
      ADDR_PU:         rd_data = widen(pu_r);
      ADDR_PD:         rd_data = widen(pd_r);
      ADDR_CS:         rd_data = widen(cs_r);
      ADDR_SL:         rd_data = widen(sl_r);
      ADDR_IE:         rd_data = widen(ie_r);
      ADDR_RISE_EN:    rd_data = widen(rise_en_r);
      ADDR_FALL_EN:    rd_data = widen(fall_en_r);
      ADDR_IRQ_STATUS: rd_data = widen(irq_status_r);
      default:         rd_data = '0;
    endcase
  end

  // Control registers; IN, IRQ_STATUS and reserved addresses have no effect here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r     <= '0;
      oe_r      <= '0;
      pu_r      <= '0;
      pd_r      <= '0;
      cs_r      <= '0;
      sl_r      <= '0;
      ie_r      <= '1;
      rise_en_r <= '0;
      fall_en_r <= '0;
    end else if (wr_en) begin
      case (bus.req_addr)
        ADDR_OUT:     out_r     <= wdata_p;
        ADDR_OE:      oe_r      <= wdata_p;
        ADDR_PU:      pu_r      <= wdata_p;
        ADDR_PD:      pd_r      <= wdata_p;
        ADDR_CS:      cs_r      <= wdata_p;
        ADDR_SL:      sl_r      <= wdata_p;
        ADDR_IE:      ie_r      <= wdata_p;
        ADDR_RISE_EN: rise_en_r <= wdata_p;
        ADDR_FALL_EN: fall_en_r <= wdata_p;
        ADDR_OUT_SET: out_r     <= out_r | wdata_p;
        ADDR_OUT_CLR: out_r     <= out_r & ~wdata_p;
        default: ;
      endcase
    end
  end

  // Disabled inputs feed 0 into the synchronizer; a fresh edge outranks a W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      irq_status_r <= '0;
      irq_r        <= 1'b0;
    end else begin
      s1           <= pad_in & ie_r;
      s2           <= s1;
      s3           <= s2;
      irq_status_r <= (irq_status_r & ~w1c_clr) | edge_set;
      irq_r        <= |irq_status_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
    end else begin
      resp_valid_r <= accept;
      if (accept) begin
        resp_rdata_r <= bus.req_write ? 32'd0 : rd_data;
      end
    end
  end

  assign pad_out = out_r;
  assign pad_oe  = oe_r;
  assign pad_cs  = cs_r;
  assign pad_sl  = sl_r;
  assign pad_ie  = ie_r;
  assign pad_pu  = pu_r;
  assign pad_pd  = pd_r;
  assign irq     = irq_r;

endmodule
